// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte write port and FIFO status between the bus slave and the UART transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH_LOG2 = 3
);
    logic [DATA_WIDTH-1:0]    s_din;
    logic                     s_wr_en;
    logic                     s_full;
    logic                     s_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                     overflow;

    modport master (
        output s_din,
        output s_wr_en,
        input  s_full,
        input  s_empty,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  s_din,
        input  s_wr_en,
        output s_full,
        output s_empty,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a gapless 8N1 UART serialiser
module uart_tx_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int CLKS_PER_BIT    = 87
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_fifo_if.slave     s,
    output logic              tx,
    output logic              tx_busy
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;

    logic                  full;
    logic                  empty;
    logic                  wr_accept;
    logic                  pop;

    state_t                state_q,   state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic                  tx_q,      tx_d;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign wr_accept = s.s_wr_en && !full;

    assign s.s_full     = full;
    assign s.s_empty    = empty;
    assign s.fifo_count = count_q;
    assign s.overflow   = overflow_q;

    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);

    // FIFO storage: no reset needed, contents are only read behind the count
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= s.s_din;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({wr_accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A write that meets a full FIFO is lost even if a pop frees a slot on the same edge
            if (s.s_wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Serialiser state register; tx is registered so the pin never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Serialiser next state: start, 8 data bits LSB first, stop; refill straight from stop
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a frame-level model
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic tx_busy;

    uart_tx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH_LOG2(3)) bus ();

    uart_tx_fifo #(
        .DATA_WIDTH      (8),
        .FIFO_DEPTH_LOG2 (3),
        .CLKS_PER_BIT    (CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of buffered bytes plus the frame currently on the line
    logic [7:0] mq[$];
    bit         m_active  = 0;
    int         m_elapsed = 0;
    logic [7:0] m_cur     = '0;
    bit         m_ov      = 0;
    int         busy_edges = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_elapsed / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        check_eq("tx",         {31'd0, tx},              {31'd0, model_tx()});
        check_eq("tx_busy",    {31'd0, tx_busy},         {31'd0, m_active});
        check_eq("fifo_count", {28'd0, bus.fifo_count},  mq.size());
        check_eq("s_full",     {31'd0, bus.s_full},      {31'd0, mq.size() == DEPTH});
        check_eq("s_empty",    {31'd0, bus.s_empty},     {31'd0, mq.size() == 0});
        check_eq("overflow",   {31'd0, bus.overflow},    {31'd0, m_ov});
    endtask

    // One clock edge: drive inputs, advance the model with pre-edge status, check just after the edge
    task automatic step(input logic wr, input logic [7:0] d);
        bit pre_full;
        bus.s_wr_en = wr;
        bus.s_din   = wr ? d : 8'($urandom);
        @(posedge clk);
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == FRAME) m_active = 0;
        end
        pre_full = (mq.size() == DEPTH);
        if (!m_active && mq.size() != 0) begin
            m_cur     = mq.pop_front();
            m_active  = 1;
            m_elapsed = 0;
        end
        if (wr) begin
            if (pre_full) m_ov = 1;
            else          mq.push_back(d);
        end
        #1;
        if (tx_busy) busy_edges++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    // Asynchronous reset between edges; outputs must respond without a clock edge
    task automatic do_reset();
        bus.s_wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        m_active  = 0;
        m_elapsed = 0;
        m_ov      = 0;
        check_eq("rst_tx",       {31'd0, tx},             32'd1);
        check_eq("rst_busy",     {31'd0, tx_busy},        32'd0);
        check_eq("rst_count",    {28'd0, bus.fifo_count}, 32'd0);
        check_eq("rst_overflow", {31'd0, bus.overflow},   32'd0);
        check_eq("rst_empty",    {31'd0, bus.s_empty},    32'd1);
        check_eq("rst_full",     {31'd0, bus.s_full},     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        bus.s_wr_en = 1'b0;
        bus.s_din   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single byte 0xCB: 40 busy cycles
        busy_edges = 0;
        step(1'b1, 8'hCB);
        idle(50);
        check_eq("single_busy_cycles", busy_edges, 32'd40);

        // Back-to-back frames with no gap
        busy_edges = 0;
        step(1'b1, 8'd231);
        step(1'b1, 8'd153);
        idle(90);
        check_eq("b2b_busy_cycles", busy_edges, 32'd80);

        // Fill and overflow: 1 popped, 2..9 buffered, 10 dropped
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i));
        check_eq("fill_count",    {28'd0, bus.fifo_count}, 32'd8);
        check_eq("fill_full",     {31'd0, bus.s_full},     32'd1);
        check_eq("fill_overflow", {31'd0, bus.overflow},   32'd1);
        idle(9 * FRAME + 5);
        check_eq("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        do_reset();

        // Wrap-around: three rounds of six bytes, drained each time
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
            idle(6 * FRAME + 5);
            check_eq("wrap_empty", {31'd0, bus.s_empty}, 32'd1);
        end

        // Write while full on the same edge as the stop-end pop
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i));
        guard = 0;
        while (!(m_active && m_elapsed == FRAME - 1) && guard < 100) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check_eq("stop_end_reached", {31'd0, guard < 100}, 32'd1);
        step(1'b1, 8'hEE);
        check_eq("full_pop_count",    {28'd0, bus.fifo_count}, 32'd7);
        check_eq("full_pop_overflow", {31'd0, bus.overflow},   32'd1);
        idle(8 * FRAME + 5);

        // Mid-frame reset aborts the frame
        do_reset();
        step(1'b1, 8'h5A);
        idle(15);
        do_reset();
        idle(5);

        // Randomized traffic in light and heavy phases
        for (int ph = 0; ph < 4; ph++) begin
            int pct;
            pct = (ph % 2 == 0) ? 3 : 30;
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 99) < pct, 8'($urandom));
            end
        end
        idle(DEPTH * FRAME + FRAME + 5);
        check_eq("final_empty", {31'd0, bus.s_empty}, 32'd1);
        check_eq("final_idle",  {31'd0, tx_busy},     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
